// File: rtl/nvdla_cmac_qchannel_ctrl.sv
// Initiator end of the CMAC Q-channel: sequences partial-retention entry/exit.
// Optional post-deny request hold-off enabled by defining NV_QCTRL_DENY_BACKOFF_EN.
module nvdla_cmac_qchannel_ctrl #(
  parameter int IDLE_THRESH    = 64,
  parameter int CNT_W          = 8,
  parameter int PWRUP_CYCLES   = 4,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic       sw_pd_req_i,
  input  logic       dev_idle_i,
  input  logic       wake_req_i,
  input  logic       qacceptn,
  input  logic       qdeny,
  output logic       qreqn,
  output logic       pwr_gate_o,
  output logic       pr_restore,
  output logic [2:0] qstate_o,
  output logic       deny_o
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_REQ     = 3'd1,
    ST_STOPPED = 3'd2,
    ST_PWRUP   = 3'd3,
    ST_RESTORE = 3'd4,
    ST_EXIT    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] IDLE_MAX   = CNT_W'(IDLE_THRESH);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'((PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic             wake_pend_q, wake_pend_d;
  logic             qreqn_q, qreqn_d;
  logic             pwr_gate_q, pwr_gate_d;
  logic             pr_restore_q, pr_restore_d;
  logic             deny_q, deny_d;
  logic             backoff_ok;
  logic             pd_trigger;
  logic             deny_event;

`ifdef NV_QCTRL_DENY_BACKOFF_EN
  logic [CNT_W-1:0] backoff_cnt_q, backoff_cnt_d;
  logic             deny_seen_q, deny_seen_d;

  // deny_seen remembers that the current EXIT was caused by a deny, so only
  // that return to RUN arms the hold-off.
  always_comb begin
    deny_seen_d = 1'b0;
    if (state_q == ST_REQ)
      deny_seen_d = deny_event;
    else if (state_q == ST_EXIT)
      deny_seen_d = deny_seen_q;

    backoff_cnt_d = (backoff_cnt_q != '0) ? backoff_cnt_q - 1'b1 : '0;
    if (state_q == ST_EXIT && state_d == ST_RUN && deny_seen_q)
      backoff_cnt_d = CNT_W'(BACKOFF_CYCLES);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      backoff_cnt_q <= '0;
      deny_seen_q   <= 1'b0;
    end else begin
      backoff_cnt_q <= backoff_cnt_d;
      deny_seen_q   <= deny_seen_d;
    end
  end

  assign backoff_ok = (backoff_cnt_q == '0);
`else
  assign backoff_ok = (BACKOFF_CYCLES >= 0);
`endif

  assign deny_event = (state_q == ST_REQ) && qacceptn && qdeny;
  assign pd_trigger = sw_pd_req_i || ((IDLE_THRESH != 0) && (idle_cnt_q == IDLE_MAX));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (pd_trigger && qacceptn && !qdeny && !wake_req_i && backoff_ok)
          state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!qacceptn)
          state_d = ST_STOPPED;
        else if (qdeny)
          state_d = ST_EXIT;
      end
      ST_STOPPED: begin
        if (wake_pend_q || wake_req_i)
          state_d = (PWRUP_CYCLES > 0) ? ST_PWRUP : ST_RESTORE;
      end
      ST_PWRUP: begin
        if (pwr_cnt_q == PWRUP_LAST)
          state_d = ST_RESTORE;
      end
      ST_RESTORE: state_d = ST_EXIT;
      ST_EXIT: begin
        if (qacceptn && !qdeny)
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Idle run length only counts while staying in RUN; any break restarts it.
    idle_cnt_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN && dev_idle_i && !wake_req_i)
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;

    pwr_cnt_d = (state_q == ST_PWRUP) ? pwr_cnt_q + 1'b1 : '0;

    // A wake seen mid-handshake is held until the restore sequence starts.
    wake_pend_d = wake_pend_q;
    if (state_q == ST_REQ && wake_req_i)
      wake_pend_d = 1'b1;
    if (state_d == ST_PWRUP || state_d == ST_RESTORE)
      wake_pend_d = 1'b0;

    qreqn_d      = (state_d == ST_RUN) || (state_d == ST_EXIT);
    pwr_gate_d   = (state_d == ST_STOPPED);
    pr_restore_d = (state_d == ST_RESTORE);
    deny_d       = deny_event;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q      <= ST_RUN;
      idle_cnt_q   <= '0;
      pwr_cnt_q    <= '0;
      wake_pend_q  <= 1'b0;
      qreqn_q      <= 1'b1;
      pwr_gate_q   <= 1'b0;
      pr_restore_q <= 1'b0;
      deny_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      pwr_cnt_q    <= pwr_cnt_d;
      wake_pend_q  <= wake_pend_d;
      qreqn_q      <= qreqn_d;
      pwr_gate_q   <= pwr_gate_d;
      pr_restore_q <= pr_restore_d;
      deny_q       <= deny_d;
    end
  end

  assign qreqn      = qreqn_q;
  assign pwr_gate_o = pwr_gate_q;
  assign pr_restore = pr_restore_q;
  assign qstate_o   = state_q;
  assign deny_o     = deny_q;

endmodule

// File: tb/tb_nvdla_cmac_qchannel_ctrl.sv
// Directed bench for nvdla_cmac_qchannel_ctrl: hand-computed expectations
// plus continuous Q-channel protocol checks.
module tb_nvdla_cmac_qchannel_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sw_pd_req, dev_idle, wake_req, qacceptn, qdeny;
  logic       qreqn, pwr_gate, pr_restore, deny;
  logic [2:0] qstate;

  int checks   = 0;
  int failures = 0;

  nvdla_cmac_qchannel_ctrl dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .sw_pd_req_i    (sw_pd_req),
    .dev_idle_i     (dev_idle),
    .wake_req_i     (wake_req),
    .qacceptn       (qacceptn),
    .qdeny          (qdeny),
    .qreqn          (qreqn),
    .pwr_gate_o     (pwr_gate),
    .pr_restore     (pr_restore),
    .qstate_o       (qstate),
    .deny_o         (deny)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic qr,
                          input logic pg, input logic pr);
    chk({tag, ".qstate"},     {5'd0, qstate},   {5'd0, st});
    chk({tag, ".qreqn"},      {7'd0, qreqn},    {7'd0, qr});
    chk({tag, ".pwr_gate"},   {7'd0, pwr_gate}, {7'd0, pg});
    chk({tag, ".pr_restore"}, {7'd0, pr_restore}, {7'd0, pr});
  endtask

  // From the cycle PWRUP is entered: 4 PWRUP cycles, 1 RESTORE, EXIT, RUN.
  task automatic restore_seq(input string tag);
    chk_outs({tag, ".pwrup0"}, 3'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, ".pwrup_hold"}, {5'd0, qstate}, 8'd3);
    end
    tick();
    chk_outs({tag, ".restore"}, 3'd4, 1'b0, 1'b0, 1'b1);
    tick();
    chk_outs({tag, ".exit"}, 3'd5, 1'b1, 1'b0, 1'b0);
    qacceptn = 1'b1;
    tick();
    chk_outs({tag, ".run"}, 3'd0, 1'b1, 1'b0, 1'b0);
  endtask

  // Protocol watcher: compares each negedge snapshot with the previous one.
  logic prev_rstn = 1'b0, prev_qreqn = 1'b1, prev_pr = 1'b0;
  logic prev_qacc = 1'b1, prev_qdeny = 1'b0;

  always @(negedge clk) begin
    if (rstn && prev_rstn) begin
      if (prev_qreqn && !qreqn) begin
        checks++;
        assert (prev_qacc && !prev_qdeny) else begin
          failures++;
          $error("FAIL proto_qreqn_fall observed=%0d expected=1", prev_qacc && !prev_qdeny);
        end
      end
      if (!prev_qreqn && qreqn) begin
        checks++;
        assert (prev_qacc == prev_qdeny) else begin
          failures++;
          $error("FAIL proto_qreqn_rise observed=%0d expected=1", prev_qacc == prev_qdeny);
        end
      end
      if (!prev_pr && pr_restore) begin
        checks++;
        assert (!prev_qreqn && !prev_qacc) else begin
          failures++;
          $error("FAIL proto_pr_rise observed=%0d expected=1", !prev_qreqn && !prev_qacc);
        end
      end
      if (prev_pr) begin
        checks++;
        assert (!pr_restore && qreqn && !prev_qreqn) else begin
          failures++;
          $error("FAIL proto_pr_pulse observed=%0d expected=1", !pr_restore && qreqn && !prev_qreqn);
        end
      end
    end
    prev_rstn  = rstn;
    prev_qreqn = qreqn;
    prev_pr    = pr_restore;
    prev_qacc  = qacceptn;
    prev_qdeny = qdeny;
  end

  initial begin
    rstn = 1'b0; sw_pd_req = 1'b1; dev_idle = 1'b0; wake_req = 1'b0;
    qacceptn = 1'b1; qdeny = 1'b0;

    // Reset with a software request held
    tick(); tick();
    chk_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    chk("reset.deny", {7'd0, deny}, 8'd0);
    rstn = 1'b1;
    tick();
    chk_outs("first_req", 3'd1, 1'b0, 1'b0, 1'b0);

    // Accept two cycles later, wake ten cycles later
    sw_pd_req = 1'b0;
    tick();
    chk("req_hold", {5'd0, qstate}, 8'd1);
    qacceptn = 1'b0;
    tick();
    chk_outs("stopped", 3'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk_outs("stopped_hold", 3'd2, 1'b0, 1'b1, 1'b0);
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    restore_seq("wake");

    // Deny path
    sw_pd_req = 1'b1;
    tick();
    chk("deny.req", {5'd0, qstate}, 8'd1);
    sw_pd_req = 1'b0;
    qdeny = 1'b1;
    tick();
    chk_outs("deny.exit", 3'd5, 1'b1, 1'b0, 1'b0);
    chk("deny.pulse", {7'd0, deny}, 8'd1);
    tick();
    chk("deny.pulse_end", {7'd0, deny}, 8'd0);
    chk("deny.exit_hold", {5'd0, qstate}, 8'd5);
    qdeny = 1'b0;
    sw_pd_req = 1'b1;
    tick();
    chk("deny.run", {5'd0, qstate}, 8'd0);
`ifdef NV_QCTRL_DENY_BACKOFF_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("backoff.hold", {7'd0, qreqn}, 8'd1);
    end
`endif
    tick();
    chk_outs("reissue", 3'd1, 1'b0, 1'b0, 1'b0);
    sw_pd_req = 1'b0;

    // Wake during REQ must not be lost
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    chk("wake_in_req", {5'd0, qstate}, 8'd1);
    qacceptn = 1'b0;
    tick();
    chk_outs("wake_in_req.stopped", 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    restore_seq("pend");

    // Idle timer: 63 cycles is not enough, 64 is
    dev_idle = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    chk("idle63.qreqn", {7'd0, qreqn}, 8'd1);
    chk("idle63.state", {5'd0, qstate}, 8'd0);
    dev_idle = 1'b0;
    tick();
    dev_idle = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    chk("idle64.qreqn", {7'd0, qreqn}, 8'd1);
    tick();
    chk_outs("idle_req", 3'd1, 1'b0, 1'b0, 1'b0);
    dev_idle = 1'b0;
    qacceptn = 1'b0;
    tick();
    chk("idle.stopped", {5'd0, qstate}, 8'd2);

    // Reset during PWRUP
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    chk("rst_pwrup.enter", {5'd0, qstate}, 8'd3);
    tick();
    rstn = 1'b0;
    qacceptn = 1'b1;
    tick();
    chk_outs("rst_pwrup", 3'd0, 1'b1, 1'b0, 1'b0);
    rstn = 1'b1;
    tick(); tick();
    chk_outs("post_rst", 3'd0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
